// File: rtl/mux_arb_pkg.sv
// Shared types and the rotating-priority search used by the four-way bus arbiter.
package mux_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Returns {found, idx}: the first set bit of req, searching ptr, ptr+1, ... modulo 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [2:0] result;
    logic [1:0] idx;
    result = 3'b000;
    // Walk from the farthest offset down so the nearest requester is the last one written.
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) result = {1'b1, idx};
    end
    return result;
  endfunction

endpackage

// File: rtl/mux_nbit_x4.sv
// Combinational 4:1 mux of BUS_WIDTH-bit words, steered by the arbiter grant.
module mux_nbit_x4 #(
  parameter int BUS_WIDTH = 8
) (
  input  logic [BUS_WIDTH-1:0] a,
  input  logic [BUS_WIDTH-1:0] b,
  input  logic [BUS_WIDTH-1:0] c,
  input  logic [BUS_WIDTH-1:0] d,
  input  logic [1:0]           sel,
  output logic [BUS_WIDTH-1:0] out
);

  always_comb begin
    // NOTE: a default assignment ahead of the case keeps every path driven, so no latch is inferred.
    out = a;
    case (sel)
      2'd1:    out = b;
      2'd2:    out = c;
      2'd3:    out = d;
      default: out = a;
    endcase
  end

endmodule

// File: rtl/mux_arbiter_rr_x4.sv
// Round-robin, burst-limited arbiter sharing one registered valid/ready output among four requesters.
module mux_arbiter_rr_x4
  import mux_arb_pkg::*;
#(
  parameter int BUS_WIDTH = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [3:0]           req,
  input  logic [BUS_WIDTH-1:0] a,
  input  logic [BUS_WIDTH-1:0] b,
  input  logic [BUS_WIDTH-1:0] c,
  input  logic [BUS_WIDTH-1:0] d,
  output logic [3:0]           ack,
  output logic [1:0]           sel,
  output logic                 busy,
  output logic [BUS_WIDTH-1:0] y,
  output logic                 y_valid,
  input  logic                 y_ready
);

  localparam int              BCW       = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(MAX_BURST - 1);

  state_t                 state, state_nx;
  logic [1:0]             sel_nx, ptr, ptr_nx, arb_ptr;
  logic [BCW-1:0]         beat_cnt, beat_cnt_nx;
  logic [3:0]             arb_req;
  logic [2:0]             pick;
  logic                   load, burst_end, rel;
  logic [BUS_WIDTH-1:0]   mux_out;

  mux_nbit_x4 #(.BUS_WIDTH(BUS_WIDTH)) u_mux (
    .a   (a),
    .b   (b),
    .c   (c),
    .d   (d),
    .sel (sel),
    .out (mux_out)
  );

  assign load      = (state == GRANT) && req[sel] && (!y_valid || y_ready);
  assign burst_end = load && (beat_cnt == LAST_BEAT);
  assign rel       = (state == GRANT) && (!req[sel] || burst_end);

  // On release the search restarts just past the old grant; an expired burst may not re-win at once.
  assign arb_ptr = (state == GRANT) ? sel + 2'd1 : ptr;
  assign arb_req = burst_end ? (req & ~(4'b0001 << sel)) : req;
  assign pick    = rr_pick(arb_req, arb_ptr);

  assign ack  = load ? (4'b0001 << sel) : 4'b0000;
  assign busy = (state == GRANT);

  always_comb begin
    state_nx    = state;
    sel_nx      = sel;
    ptr_nx      = ptr;
    beat_cnt_nx = beat_cnt;
    case (state)
      IDLE: begin
        if (pick[2]) begin
          state_nx    = GRANT;
          sel_nx      = pick[1:0];
          beat_cnt_nx = '0;
        end
      end
      GRANT: begin
        if (rel) begin
          ptr_nx      = sel + 2'd1;
          beat_cnt_nx = '0;
          if (pick[2]) sel_nx = pick[1:0];
          else         state_nx = IDLE;
        end else if (load) begin
          beat_cnt_nx = beat_cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      sel      <= 2'd0;
      ptr      <= 2'd0;
      beat_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments let every register see pre-edge values, avoiding order-dependent races.
      state    <= state_nx;
      sel      <= sel_nx;
      ptr      <= ptr_nx;
      beat_cnt <= beat_cnt_nx;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      y       <= '0;
      y_valid <= 1'b0;
    end else if (load) begin
      y       <= mux_out;
      y_valid <= 1'b1;
    end else if (y_valid && y_ready) begin
      y_valid <= 1'b0;
    end
  end

endmodule
